// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: buffered UART transmitter.
// Words enter a FIFO through a valid/ready port and are sent back-to-back on
// uart_txd with a configurable payload width, stop bit count, runtime parity
// mode and CTS flow control sampled only at frame boundaries.
module uart_tx_fifo #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic [1:0]                    parity_mode,
    input  logic                          cts_n,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(PAYLOAD_BITS);

    localparam logic [CW-1:0] CYC_LAST   = CW'(CYCLES_PER_BIT - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] DATA_LAST  = BW'(PAYLOAD_BITS - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_count;

    // CTS synchroniser (idles at 1 = not clear to send)
    logic                    r_cts_meta;
    logic                    r_cts_sync;

    // Frame engine
    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_cyc;
    logic [BW-1:0]           r_bit_idx;
    logic                    r_stop_idx;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_par_en;
    logic                    r_par_bit;
    logic                    r_txd;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_bit_end;
    logic                    w_can_start;
    logic                    w_txd;

    assign tx_ready     = (r_count != FULL_LEVEL);
    assign w_push       = tx_valid && tx_ready;
    assign w_bit_end    = (r_cyc == CYC_LAST);
    assign w_can_start  = (r_count != '0) && !r_cts_sync;
    assign fifo_level   = r_count;
    assign uart_txd     = r_txd;
    assign uart_tx_busy = (r_state != S_IDLE) || (r_count != '0);

    // FIFO storage write; no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous cts_n input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    // Next-state logic; a frame starts (and pops the FIFO head) only from
    // IDLE or at the very end of the last stop bit
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_start) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == DATA_LAST)) begin
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_stop_idx == STOP_LAST)) begin
                    if (w_can_start) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, bit-time counter, bit indices and the frame's latched payload
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + 1'b1;
            end

            if (r_state == S_START) begin
                r_bit_idx <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (r_state != S_STOP) begin
                r_stop_idx <= 1'b0;
            end else if (w_bit_end) begin
                r_stop_idx <= r_stop_idx + 1'b1;
            end

            // Payload and parity mode are captured once per frame, so later
            // changes on tx_data or parity_mode cannot disturb it
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                r_par_bit <= (^r_mem[r_rd_ptr]) ^ (parity_mode == 2'd2);
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= {1'b0, r_shift[PAYLOAD_BITS-1:1]};
            end
        end
    end

    // Line level implied by the current state
    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            S_START:  w_txd = 1'b0;
            S_DATA:   w_txd = r_shift[0];
            S_PARITY: w_txd = r_par_bit;
            default:  w_txd = 1'b1;
        endcase
    end

    // Registered line driver; reset forces the line idle immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_txd <= 1'b1;
        end else begin
            r_txd <= w_txd;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Testbench for uart_tx_fifo: directed stimulus pushes expected frames into a
// scoreboard queue; a line monitor decodes uart_txd cycle by cycle and
// compares each frame against the queue head.
module tb_uart_tx_fifo;

    localparam int CPB = 10;  // 50 MHz / 5 Mbit/s

    typedef struct {
        logic [15:0] bits;     // line level per bit time, index 0 = start bit
        int          len;      // number of bit times in the frame
        logic [8:0]  data;
        bit          aborted;  // frame is expected to be cut short by reset
    } frame_t;

    logic       clk;
    logic       resetn;

    // Instance A: 8 data bits, 1 stop bit, depth 4
    logic       tx_valid_a;
    logic       tx_ready_a;
    logic [7:0] tx_data_a;
    logic [1:0] parity_a;
    logic       cts_a;
    logic       txd_a;
    logic       busy_a;
    logic [2:0] level_a;

    // Instance B: 7 data bits, 2 stop bits, depth 4
    logic       tx_valid_b;
    logic       tx_ready_b;
    logic [6:0] tx_data_b;
    logic [1:0] parity_b;
    logic       cts_b;
    logic       txd_b;
    logic       busy_b;
    logic [2:0] level_b;

    logic       sel_b;
    logic       mon_txd;

    frame_t     exp_q[$];
    int         mon_starts[$];
    int         cyc;
    int         n_checks;
    int         n_errors;

    uart_tx_fifo #(
        .BIT_RATE(5_000_000), .CLK_HZ(50_000_000),
        .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .resetn(resetn),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
        .parity_mode(parity_a), .cts_n(cts_a),
        .uart_txd(txd_a), .uart_tx_busy(busy_a), .fifo_level(level_a)
    );

    uart_tx_fifo #(
        .BIT_RATE(5_000_000), .CLK_HZ(50_000_000),
        .PAYLOAD_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .resetn(resetn),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
        .parity_mode(parity_b), .cts_n(cts_b),
        .uart_txd(txd_b), .uart_tx_busy(busy_b), .fifo_level(level_b)
    );

    assign mon_txd = sel_b ? txd_b : txd_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Build the expected line pattern of one frame
    function automatic frame_t mk(input logic [8:0] d, input int pb,
                                  input bit par_en, input bit par_bit,
                                  input int sb, input bit ab);
        frame_t f;
        int k;
        f.bits = '1;
        k = 0;
        f.bits[k] = 1'b0;
        k++;
        for (int i = 0; i < pb; i++) begin
            f.bits[k] = d[i];
            k++;
        end
        if (par_en) begin
            f.bits[k] = par_bit;
            k++;
        end
        for (int i = 0; i < sb; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len     = k;
        f.data    = d;
        f.aborted = ab;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(posedge clk);
        #1 tx_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [6:0] d);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        @(posedge clk);
        #1 tx_valid_b = 1'b0;
    endtask

    task automatic wait_busy_low(input bit use_b, input int max_cycles);
        int k;
        k = 0;
        while (((use_b ? busy_b : busy_a) === 1'b1) && (k < max_cycles)) begin
            @(negedge clk);
            k++;
        end
        check("busy_drop", {31'd0, (use_b ? busy_b : busy_a)}, 32'd0);
    endtask

    task automatic wait_starts(input int n, input int max_cycles);
        int k;
        k = 0;
        while ((mon_starts.size() < n) && (k < max_cycles)) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", mon_starts.size(), n);
    endtask

    // Count how many of the next n negedges see the line high
    task automatic count_idle(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mon_txd === 1'b1) highs++;
        end
    endtask

    // Line monitor / scoreboard checker
    frame_t mf;
    int     m_bad;
    int     m_first;
    bit     m_ab;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if ((resetn === 1'b1) && (mon_txd === 1'b0)) begin
                mon_starts.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_frame: start bit with empty scoreboard, got line=0, expected idle 1 (cycle %0d)", cyc);
                    repeat (100) @(negedge clk);
                end else begin
                    mf      = exp_q.pop_front();
                    m_bad   = 0;
                    m_first = -1;
                    m_ab    = 1'b0;
                    for (int s = 0; s < mf.len * CPB; s++) begin
                        if (s > 0) @(negedge clk);
                        if (resetn !== 1'b1) begin
                            m_ab = 1'b1;
                            break;
                        end
                        if (mon_txd !== mf.bits[s / CPB]) begin
                            if (m_bad == 0) m_first = s;
                            m_bad++;
                        end
                    end
                    if ((m_bad != 0) || (m_ab != mf.aborted)) begin
                        n_errors++;
                        $display("FAIL frame_0x%0h: got %0d bad samples (first at %0d) aborted=%0b, expected line bits %b (LSB first) aborted=%0b",
                                 mf.data, m_bad, m_first, m_ab, mf.bits, mf.aborted);
                    end else begin
                        $display("frame data=0x%0h len=%0d aborted=%0b matched at cycle %0d",
                                 mf.data, mf.len, m_ab, cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    int highs;
    int n_lat;
    int prev_lvl;
    int n_chg;
    logic [31:0] lv_seq;
    logic [7:0]  words [0:4];

    initial begin : stim
        cyc        = 0;
        n_checks   = 0;
        n_errors   = 0;
        sel_b      = 1'b0;
        resetn     = 1'b0;
        tx_valid_a = 1'b0;
        tx_data_a  = '0;
        parity_a   = 2'd0;
        cts_a      = 1'b0;
        tx_valid_b = 1'b0;
        tx_data_b  = '0;
        parity_b   = 2'd0;
        cts_b      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_txd",   {31'd0, txd_a},      32'd1);
        check("reset_ready", {31'd0, tx_ready_a}, 32'd1);
        check("reset_busy",  {31'd0, busy_a},     32'd0);
        check("reset_level", {29'd0, level_a},    32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 frame of 0xA5
        exp_q.push_back(mk(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0));
        push_a(8'hA5);
        check("level_after_push", {29'd0, level_a}, 32'd1);
        check("busy_after_push",  {31'd0, busy_a},  32'd1);
        wait_busy_low(1'b0, 300);
        repeat (5) @(negedge clk);

        // Even parity on 0xA5 (four ones -> 0); mode and data change mid-frame
        parity_a = 2'd1;
        exp_q.push_back(mk(9'h0A5, 8, 1'b1, 1'b0, 1, 1'b0));
        push_a(8'hA5);
        repeat (40) @(posedge clk);
        #1 parity_a = 2'd2;
        tx_data_a = 8'h00;
        wait_busy_low(1'b0, 300);
        repeat (5) @(negedge clk);

        // Odd parity on 0xA5 (-> 1); mode dropped to none mid-frame
        exp_q.push_back(mk(9'h0A5, 8, 1'b1, 1'b1, 1, 1'b0));
        push_a(8'hA5);
        repeat (40) @(posedge clk);
        #1 parity_a = 2'd0;
        wait_busy_low(1'b0, 300);
        repeat (5) @(negedge clk);

        // CTS held off: five pushes into a depth-4 FIFO, only four accepted
        cts_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mon_starts.delete();
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(mk({1'b0, words[i]}, 8, 1'b0, 1'b0, 1, 1'b0));
            push_a(words[i]);
        end
        check("full_ready", {31'd0, tx_ready_a}, 32'd0);
        check("full_level", {29'd0, level_a},    32'd4);
        check("full_busy",  {31'd0, busy_a},     32'd1);
        count_idle(50, highs);
        check("cts_hold_line_idle", highs, 32'd50);

        // Release CTS: four back-to-back frames, level steps 3,2,1,0
        @(posedge clk);
        #1 cts_a = 1'b0;
        lv_seq   = '0;
        n_chg    = 0;
        prev_lvl = 4;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (int'(level_a) != prev_lvl) begin
                prev_lvl = int'(level_a);
                lv_seq   = (lv_seq << 4) | {29'd0, level_a};
                n_chg++;
            end
            if (busy_a === 1'b0) break;
        end
        check("level_sequence", lv_seq, 32'h3210);
        check("level_changes",  n_chg,  32'd4);
        repeat (5) @(negedge clk);
        check("burst_frames", mon_starts.size(), 32'd4);
        for (int i = 1; i < mon_starts.size(); i++) begin
            check("burst_gap", mon_starts[i] - mon_starts[i-1], 32'd100);
        end

        // CTS deasserted during frame 2 of 3
        mon_starts.delete();
        exp_q.push_back(mk(9'h03C, 8, 1'b0, 1'b0, 1, 1'b0));
        exp_q.push_back(mk(9'h0C3, 8, 1'b0, 1'b0, 1, 1'b0));
        exp_q.push_back(mk(9'h081, 8, 1'b0, 1'b0, 1, 1'b0));
        push_a(8'h3C);
        push_a(8'hC3);
        push_a(8'h81);
        wait_starts(2, 400);
        repeat (20) @(posedge clk);
        #1 cts_a = 1'b1;
        repeat (90) @(negedge clk);
        count_idle(50, highs);
        check("cts_wait_line_idle", highs, 32'd50);
        check("cts_wait_level", {29'd0, level_a}, 32'd1);
        @(posedge clk);
        #1 cts_a = 1'b0;
        n_lat = 0;
        do begin
            @(negedge clk);
            n_lat++;
        end while ((txd_a !== 1'b0) && (n_lat < 20));
        n_checks++;
        if (!((n_lat - 1) inside {3, 4})) begin
            n_errors++;
            $display("FAIL cts_latency: got %0d cycles, expected 3 to 4", n_lat - 1);
        end
        wait_busy_low(1'b0, 300);
        repeat (5) @(negedge clk);

        // Reset in the middle of DATA with two words queued
        mon_starts.delete();
        exp_q.push_back(mk(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1));
        push_a(8'h5A);
        push_a(8'h66);
        push_a(8'h99);
        check("queued_before_reset", {29'd0, level_a}, 32'd2);
        wait_starts(1, 100);
        repeat (35) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("abort_txd",   {31'd0, txd_a},      32'd1);
        check("abort_level", {29'd0, level_a},    32'd0);
        check("abort_busy",  {31'd0, busy_a},     32'd0);
        check("abort_ready", {31'd0, tx_ready_a}, 32'd1);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        count_idle(300, highs);
        check("post_reset_idle",  highs, 32'd300);
        check("post_reset_level", {29'd0, level_a}, 32'd0);

        // 7 data bits, 2 stop bits: 0x7F then 0x05, 100 cycles per frame
        sel_b = 1'b1;
        mon_starts.delete();
        exp_q.push_back(mk(9'h07F, 7, 1'b0, 1'b0, 2, 1'b0));
        exp_q.push_back(mk(9'h005, 7, 1'b0, 1'b0, 2, 1'b0));
        push_b(7'h7F);
        push_b(7'h05);
        wait_busy_low(1'b1, 400);
        repeat (5) @(negedge clk);
        check("b_frames", mon_starts.size(), 32'd2);
        if (mon_starts.size() == 2) begin
            check("b_frame_gap", mon_starts[1] - mon_starts[0], 32'd100);
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered, parametrised UART transmitter.
- Bytes enter through a valid/ready write port into an internal FIFO. The block serialises them back-to-back on uart_txd with configurable payload width, stop bits, runtime parity mode and hardware CTS flow control.
- Sits between the application packet logic and the TX pin. It replaces the single-byte unbuffered transmitter wherever sustained line-rate output is required.

Parameters:
BIT_RATE, 9600, line bit rate in bits/s.
CLK_HZ, 50_000_000, clk frequency in Hz; CYCLES_PER_BIT = CLK_HZ / BIT_RATE (integer division, must be >= 2).
PAYLOAD_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock.
resetn  in  1  asynchronous active-low reset.
tx_valid  in  1  write request; a word is accepted on a clk edge where tx_valid && tx_ready.
tx_ready  out  1  FIFO not full.
tx_data  in  PAYLOAD_BITS  word to enqueue.
parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none; sampled when a frame starts.
cts_n  in  1  asynchronous clear-to-send, active low; internally double-flopped.
uart_txd  out  1  serial output, registered.
uart_tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - uart_txd = 1, tx_ready = 1, uart_tx_busy = 0, fifo_level = 0.
  - FIFO pointers cleared; FSM goes to IDLE; CTS synchroniser resets to 1 (not clear).
  - Reset mid-frame aborts the frame immediately. uart_txd returns to 1 asynchronously, and queued data is discarded.
- FIFO:
  - Simultaneous push and pop leaves the level unchanged.
  - A push while full is ignored; tx_ready is low, so no data is lost.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is updated on the edge after the push or pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty and the synchronised cts_n = 0. On that edge, pop the head into the shift register and latch parity_mode.
  - START lasts one bit time, then -> DATA.
  - DATA shifts PAYLOAD_BITS bits, LSB first, one bit time each.
  - After the last data bit: -> PARITY if the latched mode is even or odd, else -> STOP.
  - PARITY lasts one bit time. The bit is XOR of the data bits for even mode and its inverse for odd mode.
  - STOP lasts STOP_BITS bit times with uart_txd = 1.
  - At the end of STOP: if the FIFO is non-empty and CTS is asserted -> START directly (no idle bit), else -> IDLE.
- Bit timing:
  - A cycle counter runs 0..CYCLES_PER_BIT-1 in every non-IDLE state. Each bit occupies exactly CYCLES_PER_BIT clk cycles on uart_txd.
  - uart_txd is a register driven from the state; it goes low one cycle after the IDLE->START edge.
- CTS:
  - cts_n is checked only at frame boundaries. Deasserting it mid-frame never truncates the frame.
  - Latency from a cts_n falling edge to the start bit is 2–3 clk cycles of synchroniser delay plus 1 cycle for the output register.
- parity_mode or tx_data changes during a frame do not affect that frame.
- Frame length = (1 + PAYLOAD_BITS + P + STOP_BITS) × CYCLES_PER_BIT cycles, where P = 1 if parity is enabled, else 0.
- uart_tx_busy deasserts on the cycle the FSM re-enters IDLE with the FIFO empty.

Test Plan:
- CLK_HZ = 50e6, BIT_RATE = 5e6 (10 cycles/bit), 8N1, push 0xA5 with cts_n = 0 -> uart_txd: 0 for 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then 1 for 10 cycles. Frame is 100 cycles; uart_tx_busy then drops.
- Same setup with parity_mode = 1, then 2, sending 0xA5 (four ones) -> parity bit 0 for even, 1 for odd; frame is 110 cycles. Change parity_mode mid-frame -> no effect on the bit.
- FIFO_DEPTH = 4, cts_n = 1, push 5 words back-to-back -> 4 accepted, tx_ready = 0, fifo_level = 4, uart_txd stays 1.
- Continuing: release cts_n = 0 -> four frames sent back-to-back with no idle gap, in order, and fifo_level counts 3, 2, 1, 0.
- Raise cts_n during frame 2 of 3 -> frame 2 completes; frame 3 waits with uart_txd = 1 until cts_n = 0, then starts after 3–4 cycles.
- Assert resetn = 0 in the middle of the DATA state with 2 words queued -> uart_txd = 1 and fifo_level = 0 immediately. After release, no transmission occurs.
- PAYLOAD_BITS = 7, STOP_BITS = 2, push 0x7F -> frame shows 7 data ones, then 2 stop bit-times; 100 cycles total with no parity.
